cursor_position_ctrl: RTL
=========================

CURSOR_POSITION_CTRL -- requirements
Module: cursor_position_ctrl

Interface
REQ-001 Parameter GRID_W, 160: grid width in cells; x range 0..GRID_W-1 (GRID_W <= 256).
REQ-002 Parameter GRID_H, 120: grid height in cells; y range 0..GRID_H-1 (GRID_H <= 256).
REQ-003 Parameter REPEAT_DELAY, 25000000: cycles a direction is held before auto-repeat starts (0.5 s at 50 MHz), >= 2.
REQ-004 Parameter REPEAT_PERIOD, 5000000: cycles between auto-repeat steps, >= 1.
REQ-005 clock  in  1  single system clock; all state on rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 btn_up, btn_down, btn_left, btn_right  in  1 each  active-high direction requests, already synchronised to clock and debounced.
REQ-008 home  in  1  active-high pulse or level; returns cursor to home cell.
REQ-009 x_pos  out  8  current cursor cell x, registered; feeds the hex position display.
REQ-010 y_pos  out  8  current cursor cell y, registered; feeds the hex position display.
REQ-011 moved  out  1  one-cycle pulse, registered, high in the cycle after any x_pos/y_pos change.

Function
REQ-012 Effective step: dx = right-left, dy = down-up; opposing buttons cancel on that axis; both axes may step in the same cycle (diagonal).
REQ-013 Direction vector dir = {btn_up, btn_down, btn_left, btn_right} is registered each cycle as dir_q; a "change" is dir != dir_q.
REQ-014 FSM states: IDLE, DELAY, REPEAT; one down-counter shared by DELAY and REPEAT.
REQ-015 IDLE: on change to nonzero dir: apply one step, load counter REPEAT_DELAY-1, go to DELAY.
REQ-016 DELAY: dir == 0 -> IDLE, no step; change to a different nonzero dir -> apply one step, reload REPEAT_DELAY-1, stay; counter == 0 -> apply one step, load REPEAT_PERIOD-1, go to REPEAT; otherwise decrement.
REQ-017 REPEAT: dir == 0 -> IDLE; change to a different nonzero dir -> apply one step, load REPEAT_DELAY-1, go to DELAY; counter == 0 -> apply one step, reload REPEAT_PERIOD-1; otherwise decrement.
REQ-018 A step is applied on the edge that samples the triggering condition; new x_pos/y_pos is visible one cycle after the button edge is presented.
REQ-019 An axis whose net step is zero leaves its coordinate unchanged; if neither coordinate changes, moved stays 0.
REQ-020 Boundary (default build): x clamps to [0, GRID_W-1]; y clamps to [0, GRID_H-1]; a step at the edge produces no change and no moved pulse.
REQ-021 home has priority over any step: when home=1, x_pos=GRID_W/2 and y_pos=GRID_H/2 at the next edge, FSM -> IDLE, counter cleared; moved pulses only if position changed.
REQ-022 While home is held, direction inputs are ignored; after release, a still-held direction counts as a new change from zero.
REQ-023 Counter width = clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); coordinate arithmetic uses 9-bit signed intermediates so no 8-bit wrap occurs in the clamp logic.

Reset
REQ-024 resetn=0 at a rising edge: x_pos=GRID_W/2 (80), y_pos=GRID_H/2 (60), moved=0, dir_q=0, FSM=IDLE, counter=0.
REQ-025 Reset asserted mid-DELAY or mid-REPEAT aborts the sequence; a button still held after release of reset is treated as a fresh press (one immediate step).

Configuration
REQ-026 Macro CURSOR_WRAP_EN: when defined, the edge behaviour is wrap-around (x GRID_W-1 +1 -> 0, x 0 -1 -> GRID_W-1; same for y with GRID_H) and moved pulses on every wrap; when undefined, clamp per REQ-020. Nothing else differs.

Verification (bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-027 Reset released, no buttons -> x_pos=80, y_pos=60, moved=0 indefinitely.
REQ-028 btn_right held 20 cycles from (80,60) -> steps at cycle 1, 9, 13, 17 -> x_pos=84, y_pos=60; four single-cycle moved pulses.
REQ-029 btn_up and btn_down held together with btn_left one cycle -> x_pos=79, y_pos=60 (vertical cancels).
REQ-030 Cursor at (159,0), tap btn_right then btn_up -> clamp build: stays (159,0), moved=0; CURSOR_WRAP_EN build: (0,0) then (0,119), moved pulses twice.
REQ-031 btn_down held, home pulsed mid-REPEAT -> next cycle (80,60), FSM IDLE; one step to (80,61) the cycle after home falls.
REQ-032 resetn driven low mid-DELAY with btn_left held, then released -> (80,60) during reset, (79,60) one cycle after release.

Source files
------------

// File: rtl/cursor_position_ctrl.sv
// rtl/cursor_position_ctrl.sv - grid cursor position controller with hold-to-repeat
//
// Moves an (x,y) cursor over a GRID_W x GRID_H cell grid from four debounced
// direction buttons. A fresh press steps once. Holding a direction steps again
// after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles after that.
//
// Build option: define CURSOR_WRAP_EN for wrap-around at the grid edges;
// without it the cursor clamps at the edges.
//
// Ports:
//   clock      - system clock, all state on the rising edge
//   resetn     - synchronous active-low reset
//   btn_up     - request a step towards row 0
//   btn_down   - request a step towards row GRID_H-1
//   btn_left   - request a step towards column 0
//   btn_right  - request a step towards column GRID_W-1
//   home       - return the cursor to the grid centre; overrides the buttons
//   x_pos      - registered cursor column
//   y_pos      - registered cursor row
//   moved      - one-cycle pulse coincident with a new x_pos/y_pos value

module cursor_position_ctrl #(
  parameter int GRID_W        = 160,
  parameter int GRID_H        = 120,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       home,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic       moved
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  localparam logic [7:0] HOME_X = 8'(GRID_W / 2);
  localparam logic [7:0] HOME_Y = 8'(GRID_H / 2);

  // Highest legal coordinate, held as 9-bit signed so the sum of an 8-bit
  // coordinate and a -1/0/+1 step can be compared without wrapping.
  localparam logic signed [8:0] X_MAX = 9'(GRID_W - 1);
  localparam logic signed [8:0] Y_MAX = 9'(GRID_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dir_q, dir_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic             moved_q, moved_d;

  logic [3:0]       dir;
  logic             dir_change;
  logic             step;
  logic signed [1:0] dx;
  logic signed [1:0] dy;

  // Apply a -1/0/+1 step to one coordinate and resolve the grid edge.
  function automatic logic [7:0] next_coord(input logic [7:0]        cur,
                                             input logic signed [1:0] d,
                                             input logic signed [8:0] maxv);
    logic signed [8:0] sum;
    logic [7:0]        res;
    sum = $signed({1'b0, cur}) + $signed({{7{d[1]}}, d});
`ifdef CURSOR_WRAP_EN
    if (sum[8]) begin
      res = maxv[7:0];
    end else if (sum > maxv) begin
      res = 8'd0;
    end else begin
      res = sum[7:0];
    end
`else
    if (sum[8]) begin
      res = 8'd0;
    end else if (sum > maxv) begin
      res = maxv[7:0];
    end else begin
      res = sum[7:0];
    end
`endif
    return res;
  endfunction

  assign dir        = {btn_up, btn_down, btn_left, btn_right};
  assign dir_change = (dir != dir_q);

  // Net step per axis; opposing buttons cancel.
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    if (btn_right && !btn_left) begin
      dx = 2'sd1;
    end else if (btn_left && !btn_right) begin
      dx = -2'sd1;
    end
    if (btn_down && !btn_up) begin
      dy = 2'sd1;
    end else if (btn_up && !btn_down) begin
      dy = -2'sd1;
    end
  end

  // Repeat FSM: one shared down-counter times both the initial hold delay
  // and the repeat period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    dir_d   = dir;

    if (home) begin
      // Forcing dir_q to zero makes a still-held button look like a fresh
      // press once home is released.
      dir_d   = 4'd0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dir_change && (dir != 4'd0)) begin
            step    = 1'b1;
            cnt_d   = DELAY_LOAD;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dir == 4'd0) begin
            state_d = ST_IDLE;
          end else if (dir_change) begin
            step  = 1'b1;
            cnt_d = DELAY_LOAD;
          end else if (cnt_q == '0) begin
            step    = 1'b1;
            cnt_d   = PERIOD_LOAD;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_REPEAT: begin
          if (dir == 4'd0) begin
            state_d = ST_IDLE;
          end else if (dir_change) begin
            step    = 1'b1;
            cnt_d   = DELAY_LOAD;
            state_d = ST_DELAY;
          end else if (cnt_q == '0) begin
            step  = 1'b1;
            cnt_d = PERIOD_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Position datapath; moved is registered alongside the new position so the
  // pulse lines up with the first cycle the new value is visible.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (home) begin
      x_d = HOME_X;
      y_d = HOME_Y;
    end else if (step) begin
      x_d = next_coord(x_q, dx, X_MAX);
      y_d = next_coord(y_q, dy, Y_MAX);
    end
    moved_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 4'd0;
      x_q     <= HOME_X;
      y_q     <= HOME_Y;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
    end
  end

  assign x_pos = x_q;
  assign y_pos = y_q;
  assign moved = moved_q;

endmodule
